// File: rtl/siso_input_buffer.sv
//==============================================================================
// Module      : siso_input_buffer
// Description : Ping-pong block buffer that turns the SISO LLR/a-priori streams
//               into aligned (sys, par, apr) tuples replayed forward or reverse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module siso_input_buffer #(
    parameter int LLR_W = 16,
    parameter int MAX_K = 512,
    parameter int K_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LLR_W-1:0] in,
    input  logic             valid_in,
    input  logic [LLR_W-1:0] apriori,
    input  logic             valid_apriori,
    input  logic [K_W-1:0]   blklen,
    input  logic             rd_dir,
    output logic             in_ready,
    output logic [LLR_W-1:0] out_sys,
    output logic [LLR_W-1:0] out_par,
    output logic [LLR_W-1:0] out_apr,
    output logic [K_W-1:0]   out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             err_overflow,
    output logic             err_blklen
);

    localparam int CW      = K_W + 1;
    localparam int C_DEPTH = 2 * MAX_K;
    localparam int AW      = $clog2(C_DEPTH);
    localparam logic [CW-1:0] C_MAX_K = CW'(MAX_K);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [K_W-1:0] C_IDX_ONE = K_W'(1);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RUN  = 1'b1} rstate_t;

    // Bank 0 occupies [0, MAX_K), bank 1 occupies [MAX_K, 2*MAX_K).
    function automatic logic [AW-1:0] bank_addr(input logic bank, input logic [CW-1:0] step);
        return AW'(step) + (bank ? AW'(MAX_K) : AW'(0));
    endfunction

    logic [LLR_W-1:0] sys_mem [C_DEPTH];
    logic [LLR_W-1:0] par_mem [C_DEPTH];
    logic [LLR_W-1:0] apr_mem [C_DEPTH];

    // Write side state
    wstate_t          wst_q, wst_d;
    logic [CW-1:0]    b_q, b_d, j_q, j_d, k_wr_q, k_wr_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic [1:0][CW-1:0] k_bank_q;
    logic             err_ov_q, err_ov_d, err_bl_q, err_bl_d;

    // Read side state
    rstate_t          rst_q, rst_d;
    logic             rd_bank_q, rd_bank_d, dir_q, dir_d;
    logic [CW-1:0]    k_rd_q, k_rd_d, issued_q, issued_d;
    logic             a_valid_q, a_valid_d, a_first_q, a_first_d, a_last_q, a_last_d;
    logic [K_W-1:0]   a_idx_q, a_idx_d;
    logic [LLR_W-1:0] out_sys_q, out_sys_d, out_par_q, out_par_d, out_apr_q, out_apr_d;
    logic [K_W-1:0]   out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;

    logic             w_in_ready, w_llr_acc, w_apr_acc, w_len_bad;
    logic             w_llr_wr, w_apr_wr, w_done, w_set_full, w_clr_full, w_load;
    logic [CW-1:0]    w_k_new, w_k_eff, w_b_next, w_j_next;
    logic [AW-1:0]    w_llr_addr, w_apr_addr, w_raddr;

    assign w_in_ready = !full_q[wr_bank_q];
    assign w_llr_acc  = valid_in && w_in_ready;
    assign w_apr_acc  = valid_apriori && w_in_ready;
    assign w_len_bad  = (blklen == '0) || ({1'b0, blklen} > C_MAX_K);
    assign w_k_new    = w_len_bad ? C_MAX_K : {1'b0, blklen};

    // Before the first LLR beat the length is unknown, so leading a-priori
    // beats are bounded only by the bank depth.
    assign w_k_eff  = (wst_q == W_FILL) ? k_wr_q : (valid_in ? w_k_new : C_MAX_K);
    assign w_llr_wr = w_llr_acc && (b_q < {w_k_eff[CW-2:0], 1'b0});
    assign w_apr_wr = w_apr_acc && (j_q < w_k_eff);
    assign w_b_next = b_q + CW'(w_llr_wr);
    assign w_j_next = j_q + CW'(w_apr_wr);
    assign w_done   = (wst_q == W_FILL) && (w_b_next == {k_wr_q[CW-2:0], 1'b0})
                      && (w_j_next >= k_wr_q);

    assign w_llr_addr = bank_addr(wr_bank_q, b_q >> 1);
    assign w_apr_addr = bank_addr(wr_bank_q, j_q);
    assign w_raddr    = bank_addr(rd_bank_q, CW'(a_idx_q));

    always_ff @(posedge clk) begin
        if (w_llr_wr && !b_q[0]) sys_mem[w_llr_addr] <= in;
        if (w_llr_wr &&  b_q[0]) par_mem[w_llr_addr] <= in;
        if (w_apr_wr)            apr_mem[w_apr_addr] <= apriori;
    end

    always_comb begin
        wst_d      = wst_q;
        b_d        = w_b_next;
        j_d        = w_j_next;
        k_wr_d     = k_wr_q;
        wr_bank_d  = wr_bank_q;
        w_set_full = 1'b0;
        err_ov_d   = err_ov_q | ((valid_in || valid_apriori) && !w_in_ready);
        err_bl_d   = err_bl_q;
        case (wst_q)
            W_IDLE: begin
                if (w_llr_acc) begin
                    wst_d    = W_FILL;
                    k_wr_d   = w_k_new;
                    err_bl_d = err_bl_q | w_len_bad;
                end
            end
            W_FILL: begin
                if (w_done) begin
                    w_set_full = 1'b1;
                    wr_bank_d  = ~wr_bank_q;
                    b_d        = '0;
                    j_d        = '0;
                    wst_d      = W_IDLE;
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    // Stage 1 holds the issued address, stage 2 the registered tuple.
    assign w_load = !out_valid_q || out_ready;

    always_comb begin
        rst_d       = rst_q;
        rd_bank_d   = rd_bank_q;
        dir_d       = dir_q;
        k_rd_d      = k_rd_q;
        issued_d    = issued_q;
        a_valid_d   = a_valid_q;
        a_idx_d     = a_idx_q;
        a_first_d   = a_first_q;
        a_last_d    = a_last_q;
        w_clr_full  = 1'b0;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_sys_d   = out_sys_q;
        out_par_d   = out_par_q;
        out_apr_d   = out_apr_q;
        case (rst_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    dir_d     = rd_dir;
                    k_rd_d    = k_bank_q[rd_bank_q];
                    a_valid_d = 1'b1;
                    a_idx_d   = rd_dir ? K_W'(k_bank_q[rd_bank_q] - C_ONE) : '0;
                    a_first_d = 1'b1;
                    a_last_d  = (k_bank_q[rd_bank_q] == C_ONE);
                    issued_d  = C_ONE;
                    rst_d     = R_RUN;
                end
            end
            R_RUN: begin
                if (w_load && a_valid_q) begin
                    if (issued_q < k_rd_q) begin
                        a_idx_d   = dir_q ? a_idx_q - C_IDX_ONE : a_idx_q + C_IDX_ONE;
                        a_first_d = 1'b0;
                        a_last_d  = (issued_q == k_rd_q - C_ONE);
                        issued_d  = issued_q + C_ONE;
                    end else begin
                        a_valid_d = 1'b0;
                    end
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    w_clr_full = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    rst_d      = R_IDLE;
                end
            end
            default: rst_d = R_IDLE;
        endcase
        if (w_load) begin
            out_valid_d = a_valid_q;
            out_first_d = a_valid_q && a_first_q;
            out_last_d  = a_valid_q && a_last_q;
            if (a_valid_q) begin
                out_idx_d = a_idx_q;
                out_sys_d = sys_mem[w_raddr];
                out_par_d = par_mem[w_raddr];
                out_apr_d = apr_mem[w_raddr];
            end
        end
    end

    // Fill and release always target different banks, so both may apply at once.
    always_comb begin
        full_d = full_q;
        if (w_set_full) full_d[wr_bank_q] = 1'b1;
        if (w_clr_full) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wst_q       <= W_IDLE;
            b_q         <= '0;
            j_q         <= '0;
            k_wr_q      <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= '0;
            k_bank_q    <= '0;
            err_ov_q    <= 1'b0;
            err_bl_q    <= 1'b0;
            rst_q       <= R_IDLE;
            rd_bank_q   <= 1'b0;
            dir_q       <= 1'b0;
            k_rd_q      <= '0;
            issued_q    <= '0;
            a_valid_q   <= 1'b0;
            a_idx_q     <= '0;
            a_first_q   <= 1'b0;
            a_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_sys_q   <= '0;
            out_par_q   <= '0;
            out_apr_q   <= '0;
        end else begin
            wst_q       <= wst_d;
            b_q         <= b_d;
            j_q         <= j_d;
            k_wr_q      <= k_wr_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            if (w_set_full) k_bank_q[wr_bank_q] <= k_wr_q;
            err_ov_q    <= err_ov_d;
            err_bl_q    <= err_bl_d;
            rst_q       <= rst_d;
            rd_bank_q   <= rd_bank_d;
            dir_q       <= dir_d;
            k_rd_q      <= k_rd_d;
            issued_q    <= issued_d;
            a_valid_q   <= a_valid_d;
            a_idx_q     <= a_idx_d;
            a_first_q   <= a_first_d;
            a_last_q    <= a_last_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_sys_q   <= out_sys_d;
            out_par_q   <= out_par_d;
            out_apr_q   <= out_apr_d;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_sys      = out_sys_q;
    assign out_par      = out_par_q;
    assign out_apr      = out_apr_q;
    assign out_idx      = out_idx_q;
    assign out_valid    = out_valid_q;
    assign out_first    = out_first_q;
    assign out_last     = out_last_q;
    assign err_overflow = err_ov_q;
    assign err_blklen   = err_bl_q;

endmodule

`default_nettype wire
